// File: rtl/proto_pkg.sv
// Shared ProtoCore datapath types.
//   DATA_W / ADDR_W : register width and register-address width.
//   data_t / reg_addr_t : operand and register-index types for decode, ALU and the register file.
package proto_pkg;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int NUM_REGS = 2**ADDR_W;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/reg_file_read_mux.sv
// Combinational register select: out = regs[sel].
// Ports:
//   regs : all register contents, packed, entry i at regs[i]
//   sel  : register index
//   out  : selected register
module reg_file_read_mux #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic [2**ADDR_W-1:0][DATA_W-1:0] regs,
  input  logic [ADDR_W-1:0]                sel,
  output logic [DATA_W-1:0]                out
);
  assign out = regs[sel];
endmodule

// File: rtl/reg_file.sv
// ProtoCore general-purpose register file: 2**ADDR_W x DATA_W,
// one synchronous write port, two combinational read ports, no write-to-read bypass.
// Ports:
//   clk, rst_n     : clock; async active-low reset clears every register
//   ra, rb         : read addresses for ports A and B
//   wa, wd, we     : write address, data, enable (sampled on rising clk)
//   read_a, read_b : register[ra], register[rb]
// Build option:
//   REG_FILE_ZERO_REG_EN : register 0 reads as zero and ignores writes.
module reg_file
  import proto_pkg::*;
#(
  parameter int DATA_W = proto_pkg::DATA_W,
  parameter int ADDR_W = proto_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra,
  input  logic [ADDR_W-1:0] rb,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              we,
  output logic [DATA_W-1:0] read_a,
  output logic [DATA_W-1:0] read_b
);
  localparam int DEPTH   = 2**ADDR_W;
  localparam int NUM_RD  = 2;

  logic [DEPTH-1:0][DATA_W-1:0]  regs;
  logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr;
  logic [NUM_RD-1:0][DATA_W-1:0] rd_data;
  logic                          wr_en;

`ifdef REG_FILE_ZERO_REG_EN
  // r0 is never written, so it keeps its reset value of zero and reads back as 0.
  assign wr_en = we && (wa != '0);
`else
  assign wr_en = we;
`endif

  // wd/wa only reach storage when the write is enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     regs     <= '0;
    else if (wr_en) regs[wa] <= wd;
  end

  assign rd_addr = {rb, ra};

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    reg_file_read_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mux (
      .regs (regs),
      .sel  (rd_addr[p]),
      .out  (rd_data[p])
    );
  end

  assign read_a = rd_data[0];
  assign read_b = rd_data[1];
endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: expected read-port values are pushed to a
// scoreboard queue when stimulus is applied and popped at each check point.
module tb_reg_file;
  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] ra, rb, wa;
  logic [DW-1:0] wd;
  logic          we;
  logic [DW-1:0] read_a, read_b;

  typedef struct {
    string         tag;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    bit            chk_b;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  reg_file #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ra     (ra),
    .rb     (rb),
    .wa     (wa),
    .wd     (wd),
    .we     (we),
    .read_a (read_a),
    .read_b (read_b)
  );

  always #5 clk = ~clk;

  // Reference content for r0 after a write of v.
  function automatic logic [DW-1:0] r0_after(input logic [DW-1:0] v);
`ifdef REG_FILE_ZERO_REG_EN
    return '0;
`else
    return v;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [DW-1:0] a,
                      input logic [DW-1:0] b, input bit chk_b);
    exp_t e;
    e.tag = tag; e.a = a; e.b = b; e.chk_b = chk_b;
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty");
      return;
    end
    e = sb.pop_front();
    vectors++;
    assert (read_a === e.a) else begin
      miscompares++;
      $error("FAIL %s read_a got %h want %h", e.tag, read_a, e.a);
    end
    if (e.chk_b) begin
      vectors++;
      assert (read_b === e.b) else begin
        miscompares++;
        $error("FAIL %s read_b got %h want %h", e.tag, read_b, e.b);
      end
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    we = 1'b1; wa = a; wd = d;
    tick();
    we = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; we = 1'b0; ra = '0; rb = 4'hF; wa = '0; wd = '0;
    #2;
    push("reset_state", 8'h00, 8'h00, 1'b1); check();
    tick();
    rst_n = 1'b1;

    // Async reset: write r7, then drop rst_n mid-cycle with no clock edge.
    wr(4'd7, 8'h5A);
    ra = 4'd7;
    #1 push("r7_written", 8'h5A, 8'h00, 1'b0); check();
    rst_n = 1'b0;
    #1 push("async_reset", 8'h00, 8'h00, 1'b0); check();

    // Reset dominates a pending write across an edge.
    we = 1'b1; wa = 4'd2; wd = 8'h77; ra = 4'd2;
    tick();
    push("reset_blocks_wr", 8'h00, 8'h00, 1'b0); check();
    #1 rst_n = 1'b1;
    tick();
    we = 1'b0;
    push("wr_after_reset", 8'h77, 8'h00, 1'b0); check();

    // Fill and dual-port sweep.
    for (int i = 0; i < 16; i++) wr(AW'(i), DW'(i * 8'h11));
    for (int i = 0; i < 16; i++) begin
      logic [DW-1:0] ea, eb;
      ra = AW'(i); rb = AW'(15 - i);
      ea = (i == 0)  ? r0_after(8'h00) : DW'(i * 8'h11);
      eb = (i == 15) ? r0_after(8'h00) : DW'((15 - i) * 8'h11);
      #1 push("sweep", ea, eb, 1'b1); check();
    end

    // Overwrite, ra == rb.
    wr(4'd3, 8'hAA);
    ra = 4'd3; rb = 4'd3;
    #1 push("overwrite_r3", 8'hAA, 8'hAA, 1'b1); check();

    // we=0 holds contents regardless of wa/wd.
    we = 1'b0; wa = 4'd5; wd = 8'h11; ra = 4'd5;
    tick(); tick();
    push("we_off_r5", 8'h55, 8'h00, 1'b0); check();

    // Same-address read/write: old value until the edge, new after.
    ra = 4'd9; we = 1'b1; wa = 4'd9; wd = 8'h3C;
    #1 push("rw_before_edge", 8'h99, 8'h00, 1'b0); check();
    tick();
    we = 1'b0;
    push("rw_after_edge", 8'h3C, 8'h00, 1'b0); check();

    // r0 behaviour depends on build option.
    wr(4'd0, 8'hFF);
    ra = 4'd0; rb = 4'd0;
    #1 push("r0_write", r0_after(8'hFF), r0_after(8'hFF), 1'b1); check();

    // Neighbours untouched by earlier writes.
    ra = 4'd1; rb = 4'd15;
    #1 push("neighbours", 8'h11, 8'hFF, 1'b1); check();

    if (sb.size() != 0) begin
      miscompares++;
      $error("FAIL scoreboard_leftover got %0d want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
